// File: rtl/apb_timer.sv
// ---------------------------------------------------------------------------
// apb_timer
//   Zero-wait-state APB slave holding a 32-bit down-counting timer with an
//   8-bit prescaler, one-shot or periodic reload, and a level interrupt.
//
//   Register map (word offsets from paddr[BASE_OFFSET_BITS-1:2]):
//     0x00 CTRL   RW  [0] EN, [1] RELOAD, [2] IE, [15:8] PRESC
//     0x04 LOAD   RW  reload value; a write also restarts VALUE and pcnt
//     0x08 VALUE  RO  current count
//     0x0C STATUS     [0] IF, write-1-to-clear
//
//   Ports:
//     pclk     clock, all state on the rising edge
//     prst     synchronous active-high reset
//     paddr    APB address (only the offset bits are decoded)
//     psel     slave select
//     penable  access phase
//     pwrite   1 = write, 0 = read
//     pwdata   write data
//     prdata   read data, combinational, 0 unless psel and a mapped offset
//     pready   constant 1
//     pslverr  error on unmapped offsets or a write to VALUE
//     irq      IF & IE
// ---------------------------------------------------------------------------
module apb_timer #(
    parameter int BASE_OFFSET_BITS = 5
) (
    input  logic        pclk,
    input  logic        prst,
    input  logic [31:0] paddr,
    input  logic        psel,
    input  logic        penable,
    input  logic        pwrite,
    input  logic [31:0] pwdata,
    output logic [31:0] prdata,
    output logic        pready,
    output logic        pslverr,
    output logic        irq
);

    localparam int OFS_W = BASE_OFFSET_BITS - 2;

    localparam logic [OFS_W-1:0] OFS_CTRL   = OFS_W'(0);
    localparam logic [OFS_W-1:0] OFS_LOAD   = OFS_W'(1);
    localparam logic [OFS_W-1:0] OFS_VALUE  = OFS_W'(2);
    localparam logic [OFS_W-1:0] OFS_STATUS = OFS_W'(3);

    // Control / status state
    logic        en;
    logic        reload;
    logic        ie;
    logic [7:0]  presc;
    logic [7:0]  pcnt;
    logic        if_flag;

    // Count state
    logic [31:0] load;
    logic [31:0] value;

    logic [OFS_W-1:0] offset;
    logic             mapped;
    logic             access;
    logic             wr_ctrl;
    logic             wr_load;
    logic             wr_status;
    logic             tick;
    logic             value_zero;
    logic             hw_set_if;

    // Address bits outside the decoded window are intentionally ignored.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{paddr[31:BASE_OFFSET_BITS], paddr[1:0]};

    assign offset = paddr[BASE_OFFSET_BITS-1:2];
    assign mapped = (offset <= OFS_STATUS);
    assign access = psel & penable;

    // Write strobes only fire for legal targets, so an erroring write
    // changes nothing.
    assign wr_ctrl   = access & pwrite & (offset == OFS_CTRL);
    assign wr_load   = access & pwrite & (offset == OFS_LOAD);
    assign wr_status = access & pwrite & (offset == OFS_STATUS);

    assign pslverr = access & (~mapped | (pwrite & (offset == OFS_VALUE)));
    assign pready  = 1'b1;

    assign tick       = en & (pcnt == presc);
    assign value_zero = (value == 32'd0);
    assign hw_set_if  = tick & value_zero;

    assign irq = if_flag & ie;

    always_comb begin
        prdata = 32'd0;
        if (psel) begin
            case (offset)
                OFS_CTRL:   prdata = {16'd0, presc, 5'd0, ie, reload, en};
                OFS_LOAD:   prdata = load;
                OFS_VALUE:  prdata = value;
                OFS_STATUS: prdata = {31'd0, if_flag};
                default:    prdata = 32'd0;
            endcase
        end
    end

    always_ff @(posedge pclk) begin
        if (prst) begin
            en      <= 1'b0;
            reload  <= 1'b0;
            ie      <= 1'b0;
            presc   <= 8'd0;
            pcnt    <= 8'd0;
            if_flag <= 1'b0;
            load    <= 32'd0;
            value   <= 32'd0;
        end else begin
            // Prescaler: a LOAD write restarts it; disabling (either by the
            // current EN or by a CTRL write clearing EN) parks it at 0.
            if (wr_load || !en || tick || (wr_ctrl && !pwdata[0])) begin
                pcnt <= 8'd0;
            end else begin
                pcnt <= pcnt + 8'd1;
            end

            // Counter: LOAD write overrides whatever the tick would do.
            if (wr_load) begin
                value <= pwdata;
            end else if (tick) begin
                if (!value_zero) begin
                    value <= value - 32'd1;
                end else if (reload) begin
                    value <= load;
                end
            end

            if (wr_load) begin
                load <= pwdata;
            end

            // A CTRL write wins over the one-shot EN clear on the same edge;
            // the tick on that edge was already evaluated with the old CTRL.
            if (wr_ctrl) begin
                en     <= pwdata[0];
                reload <= pwdata[1];
                ie     <= pwdata[2];
                presc  <= pwdata[15:8];
            end else if (hw_set_if && !reload) begin
                en <= 1'b0;
            end

            // Hardware set beats software clear.
            if (hw_set_if) begin
                if_flag <= 1'b1;
            end else if (wr_status && pwdata[0]) begin
                if_flag <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_apb_timer.sv
// ---------------------------------------------------------------------------
// tb_apb_timer
//   Directed testbench for apb_timer. Inputs change 1 ns after the rising
//   edge; outputs are sampled between edges.
// ---------------------------------------------------------------------------
`timescale 1ns/100ps
module tb_apb_timer;

    logic        pclk = 1'b0;
    logic        prst;
    logic [31:0] paddr;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;
    logic        irq;

    int errors = 0;
    int checks = 0;

    logic [31:0] d;
    logic        err;

    apb_timer #(.BASE_OFFSET_BITS(5)) dut (
        .pclk    (pclk),
        .prst    (prst),
        .paddr   (paddr),
        .psel    (psel),
        .penable (penable),
        .pwrite  (pwrite),
        .pwdata  (pwdata),
        .prdata  (prdata),
        .pready  (pready),
        .pslverr (pslverr),
        .irq     (irq)
    );

    always #5 pclk = ~pclk;

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge pclk);
            #1;
        end
    endtask

    task automatic do_reset();
        prst    = 1'b1;
        psel    = 1'b0;
        penable = 1'b0;
        pwrite  = 1'b0;
        paddr   = 32'd0;
        pwdata  = 32'd0;
        @(posedge pclk);
        #1;
        prst = 1'b0;
    endtask

    // Combinational read with psel only (no clock edge crossed).
    task automatic peek(input logic [31:0] a, output logic [31:0] v);
        paddr   = a;
        pwrite  = 1'b0;
        penable = 1'b0;
        psel    = 1'b1;
        #1;
        v    = prdata;
        psel = 1'b0;
    endtask

    // Two-edge APB write; write lands on the second edge. e = pslverr in access phase.
    task automatic apb_write(input logic [31:0] a, input logic [31:0] v, output logic e);
        paddr   = a;
        pwdata  = v;
        pwrite  = 1'b1;
        psel    = 1'b1;
        penable = 1'b0;
        @(posedge pclk);
        #1;
        penable = 1'b1;
        #1;
        e = pslverr;
        @(posedge pclk);
        #1;
        psel    = 1'b0;
        penable = 1'b0;
        pwrite  = 1'b0;
    endtask

    task automatic apb_read(input logic [31:0] a, output logic [31:0] v, output logic e);
        paddr   = a;
        pwrite  = 1'b0;
        psel    = 1'b1;
        penable = 1'b0;
        @(posedge pclk);
        #1;
        penable = 1'b1;
        #1;
        v = prdata;
        e = pslverr;
        @(posedge pclk);
        #1;
        psel    = 1'b0;
        penable = 1'b0;
    endtask

    task automatic test_reset();
        apb_write(32'h04, 32'h0000_0007, err);
        apb_write(32'h00, 32'h0000_0107, err);
        step(3);
        do_reset();
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq got=%b exp=0", irq); end
        checks++; if (pslverr !== 1'b0) begin errors++; $display("FAIL reset_pslverr got=%b exp=0", pslverr); end
        checks++; if (pready !== 1'b1) begin errors++; $display("FAIL reset_pready got=%b exp=1", pready); end
        checks++; if (prdata !== 32'd0) begin errors++; $display("FAIL reset_prdata_idle got=%h exp=0", prdata); end
        peek(32'h00, d);
        checks++; if (d !== 32'd0) begin errors++; $display("FAIL reset_ctrl got=%h exp=0", d); end
        peek(32'h04, d);
        checks++; if (d !== 32'd0) begin errors++; $display("FAIL reset_load got=%h exp=0", d); end
        peek(32'h08, d);
        checks++; if (d !== 32'd0) begin errors++; $display("FAIL reset_value got=%h exp=0", d); end
        peek(32'h0C, d);
        checks++; if (d !== 32'd0) begin errors++; $display("FAIL reset_status got=%h exp=0", d); end
    endtask

    task automatic test_regs();
        do_reset();
        apb_write(32'h00, 32'hFFFF_FFFE, err);
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL regs_ctrl_err got=%b exp=0", err); end
        apb_read(32'h00, d, err);
        checks++; if (d !== 32'h0000_FF06) begin errors++; $display("FAIL regs_ctrl_mask got=%h exp=0000ff06", d); end
        apb_write(32'h04, 32'hDEAD_BEEF, err);
        peek(32'h04, d);
        checks++; if (d !== 32'hDEAD_BEEF) begin errors++; $display("FAIL regs_load got=%h exp=deadbeef", d); end
        peek(32'h08, d);
        checks++; if (d !== 32'hDEAD_BEEF) begin errors++; $display("FAIL regs_value_from_load got=%h exp=deadbeef", d); end
        peek(32'hFFFF_FF04, d);
        checks++; if (d !== 32'hDEAD_BEEF) begin errors++; $display("FAIL regs_upper_addr got=%h exp=deadbeef", d); end
    endtask

    task automatic test_illegal();
        // State from test_regs: LOAD=VALUE=deadbeef, CTRL=ff06 (EN=0)
        apb_write(32'h08, 32'h0000_0123, err);
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL ill_wr_value_err got=%b exp=1", err); end
        peek(32'h08, d);
        checks++; if (d !== 32'hDEAD_BEEF) begin errors++; $display("FAIL ill_value_kept got=%h exp=deadbeef", d); end
        apb_read(32'h14, d, err);
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL ill_rd14_err got=%b exp=1", err); end
        checks++; if (d !== 32'd0) begin errors++; $display("FAIL ill_rd14_data got=%h exp=0", d); end
        apb_write(32'h1C, 32'h0000_0001, err);
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL ill_wr1c_err got=%b exp=1", err); end
        peek(32'h00, d);
        checks++; if (d !== 32'h0000_FF06) begin errors++; $display("FAIL ill_ctrl_kept got=%h exp=0000ff06", d); end
        apb_read(32'h08, d, err);
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL ill_rd_value_err got=%b exp=0", err); end
    endtask

    task automatic test_periodic();
        logic [31:0] exp_v;
        do_reset();
        apb_write(32'h04, 32'd4, err);
        apb_write(32'h00, 32'h0000_0007, err);
        peek(32'h08, d);
        checks++; if (d !== 32'd4) begin errors++; $display("FAIL per_value_start got=%0d exp=4", d); end
        for (int i = 3; i >= 0; i--) begin
            step(1);
            exp_v = 32'(i);
            peek(32'h08, d);
            checks++; if (d !== exp_v) begin errors++; $display("FAIL per_count got=%0d exp=%0d", d, exp_v); end
        end
        step(1);
        peek(32'h0C, d);
        checks++; if (d !== 32'd1) begin errors++; $display("FAIL per_if_set got=%0d exp=1", d); end
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL per_irq_set got=%b exp=1", irq); end
        peek(32'h08, d);
        checks++; if (d !== 32'd4) begin errors++; $display("FAIL per_reload got=%0d exp=4", d); end
        apb_write(32'h0C, 32'd1, err);
        peek(32'h0C, d);
        checks++; if (d !== 32'd0) begin errors++; $display("FAIL per_if_clr got=%0d exp=0", d); end
        peek(32'h08, d);
        checks++; if (d !== 32'd2) begin errors++; $display("FAIL per_value_mid got=%0d exp=2", d); end
        step(2);
        peek(32'h0C, d);
        checks++; if (d !== 32'd0) begin errors++; $display("FAIL per_if_early got=%0d exp=0", d); end
        step(1);
        peek(32'h0C, d);
        checks++; if (d !== 32'd1) begin errors++; $display("FAIL per_if_again got=%0d exp=1", d); end
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL per_irq_again got=%b exp=1", irq); end
    endtask

    task automatic test_oneshot();
        do_reset();
        apb_write(32'h04, 32'd2, err);
        apb_write(32'h00, 32'h0000_0301, err);
        step(3);
        peek(32'h08, d);
        checks++; if (d !== 32'd2) begin errors++; $display("FAIL os_before_tick got=%0d exp=2", d); end
        step(1);
        peek(32'h08, d);
        checks++; if (d !== 32'd1) begin errors++; $display("FAIL os_tick1 got=%0d exp=1", d); end
        step(4);
        peek(32'h08, d);
        checks++; if (d !== 32'd0) begin errors++; $display("FAIL os_tick2 got=%0d exp=0", d); end
        step(3);
        peek(32'h0C, d);
        checks++; if (d !== 32'd0) begin errors++; $display("FAIL os_if_early got=%0d exp=0", d); end
        step(1);
        peek(32'h0C, d);
        checks++; if (d !== 32'd1) begin errors++; $display("FAIL os_if_set got=%0d exp=1", d); end
        peek(32'h00, d);
        checks++; if (d !== 32'h0000_0300) begin errors++; $display("FAIL os_ctrl_en_clr got=%h exp=00000300", d); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL os_irq got=%b exp=0", irq); end
        step(4);
        peek(32'h08, d);
        checks++; if (d !== 32'd0) begin errors++; $display("FAIL os_stays_zero got=%0d exp=0", d); end
    endtask

    task automatic test_if_race();
        do_reset();
        apb_write(32'h04, 32'd4, err);
        apb_write(32'h00, 32'h0000_0007, err);
        step(5);
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL race_irq_first got=%b exp=1", irq); end
        step(3);
        // Write edge coincides with the next tick at zero.
        apb_write(32'h0C, 32'd1, err);
        peek(32'h0C, d);
        checks++; if (d !== 32'd1) begin errors++; $display("FAIL race_set_wins got=%0d exp=1", d); end
        peek(32'h08, d);
        checks++; if (d !== 32'd4) begin errors++; $display("FAIL race_value got=%0d exp=4", d); end
        apb_write(32'h0C, 32'd1, err);
        peek(32'h0C, d);
        checks++; if (d !== 32'd0) begin errors++; $display("FAIL race_clear got=%0d exp=0", d); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL race_irq_clear got=%b exp=0", irq); end
    endtask

    task automatic test_reset_midcount();
        do_reset();
        apb_write(32'h04, 32'h0000_0100, err);
        apb_write(32'h00, 32'h0000_0005, err);
        step(3);
        peek(32'h08, d);
        checks++; if (d !== 32'h0000_00FD) begin errors++; $display("FAIL rmc_running got=%h exp=000000fd", d); end
        prst    = 1'b1;
        paddr   = 32'h04;
        pwdata  = 32'h0000_0055;
        pwrite  = 1'b1;
        psel    = 1'b1;
        penable = 1'b1;
        @(posedge pclk);
        #1;
        prst    = 1'b0;
        psel    = 1'b0;
        penable = 1'b0;
        pwrite  = 1'b0;
        checks++; if (prdata !== 32'd0) begin errors++; $display("FAIL rmc_prdata_idle got=%h exp=0", prdata); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL rmc_irq got=%b exp=0", irq); end
        peek(32'h04, d);
        checks++; if (d !== 32'd0) begin errors++; $display("FAIL rmc_load got=%h exp=0", d); end
        peek(32'h00, d);
        checks++; if (d !== 32'd0) begin errors++; $display("FAIL rmc_ctrl got=%h exp=0", d); end
        step(5);
        peek(32'h08, d);
        checks++; if (d !== 32'd0) begin errors++; $display("FAIL rmc_value got=%h exp=0", d); end
        peek(32'h0C, d);
        checks++; if (d !== 32'd0) begin errors++; $display("FAIL rmc_status got=%h exp=0", d); end
    endtask

    task automatic test_load_midcount();
        do_reset();
        apb_write(32'h04, 32'd10, err);
        apb_write(32'h00, 32'h0000_0103, err);
        step(3);
        peek(32'h08, d);
        checks++; if (d !== 32'd9) begin errors++; $display("FAIL lmc_running got=%0d exp=9", d); end
        apb_write(32'h04, 32'd3, err);
        peek(32'h08, d);
        checks++; if (d !== 32'd3) begin errors++; $display("FAIL lmc_value_loaded got=%0d exp=3", d); end
        step(1);
        peek(32'h08, d);
        checks++; if (d !== 32'd3) begin errors++; $display("FAIL lmc_pcnt_restart got=%0d exp=3", d); end
        step(1);
        peek(32'h08, d);
        checks++; if (d !== 32'd2) begin errors++; $display("FAIL lmc_tick1 got=%0d exp=2", d); end
        step(5);
        peek(32'h0C, d);
        checks++; if (d !== 32'd0) begin errors++; $display("FAIL lmc_if_early got=%0d exp=0", d); end
        step(1);
        peek(32'h0C, d);
        checks++; if (d !== 32'd1) begin errors++; $display("FAIL lmc_if_set got=%0d exp=1", d); end
        peek(32'h08, d);
        checks++; if (d !== 32'd3) begin errors++; $display("FAIL lmc_reload got=%0d exp=3", d); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL lmc_irq got=%b exp=0", irq); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        apb_write(32'h04, 32'd6, err);
        apb_write(32'h00, 32'h0000_0001, err);
        step(2);
        apb_write(32'h00, 32'h0000_0000, err);
        peek(32'h08, d);
        checks++; if (d !== 32'd2) begin errors++; $display("FAIL b2b_frozen got=%0d exp=2", d); end
        step(3);
        peek(32'h08, d);
        checks++; if (d !== 32'd2) begin errors++; $display("FAIL b2b_still_frozen got=%0d exp=2", d); end
        apb_write(32'h00, 32'h0000_0001, err);
        peek(32'h08, d);
        checks++; if (d !== 32'd2) begin errors++; $display("FAIL b2b_resume got=%0d exp=2", d); end
        step(1);
        peek(32'h08, d);
        checks++; if (d !== 32'd1) begin errors++; $display("FAIL b2b_resumed got=%0d exp=1", d); end
        // CTRL write with EN=1 lands on the one-shot expiry edge.
        apb_write(32'h00, 32'h0000_0001, err);
        peek(32'h0C, d);
        checks++; if (d !== 32'd1) begin errors++; $display("FAIL b2b_if_set got=%0d exp=1", d); end
        peek(32'h00, d);
        checks++; if (d !== 32'd1) begin errors++; $display("FAIL b2b_en_kept got=%h exp=1", d); end
        step(1);
        peek(32'h00, d);
        checks++; if (d !== 32'd0) begin errors++; $display("FAIL b2b_en_cleared got=%h exp=0", d); end
    endtask

    initial begin
        prst    = 1'b1;
        psel    = 1'b0;
        penable = 1'b0;
        pwrite  = 1'b0;
        paddr   = 32'd0;
        pwdata  = 32'd0;
        step(1);
        prst = 1'b0;
        test_reset();
        test_regs();
        test_illegal();
        test_periodic();
        test_oneshot();
        test_if_race();
        test_reset_midcount();
        test_load_midcount();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/apb_timer.md
APB_TIMER -- requirements
Module: apb_timer

Interface
REQ-001 Parameter: BASE_OFFSET_BITS, default 5; number of paddr LSBs decoded (paddr[4:2] select register, upper bits ignored).
REQ-002 pclk  input  1  sole clock; all state updates on rising edge.
REQ-003 prst  input  1  reset; synchronous, active-high.
REQ-004 paddr  input  32  APB address; word offset from paddr[4:2].
REQ-005 psel  input  1  APB slave select (psel_s2 slot of the APB subsystem).
REQ-006 penable  input  1  APB access phase.
REQ-007 pwrite  input  1  1 = write, 0 = read.
REQ-008 pwdata  input  32  write data.
REQ-009 prdata  output  32  read data; valid while psel=1.
REQ-010 pready  output  1  tied 1; zero-wait-state slave.
REQ-011 pslverr  output  1  error response for illegal access.
REQ-012 irq  output  1  level interrupt to interrupt vector bit.

Function
REQ-013 Register map SHALL be: 0x00 CTRL (RW; [0] EN, [1] RELOAD, [2] IE, [15:8] PRESC, other bits read 0); 0x04 LOAD (RW, 32 bit); 0x08 VALUE (RO); 0x0C STATUS (bit [0] IF, write-1-to-clear).
REQ-014 Register write SHALL occur on the edge where psel & penable & pwrite = 1; setup phase SHALL have no side effects.
REQ-015 prdata SHALL be combinational from paddr[4:2] while psel=1, and 0 when psel=0 or offset unmapped.
REQ-016 pslverr SHALL be 1 during access phase for offsets 0x10-0x1C or any write to VALUE; such writes SHALL change no state.
REQ-017 Prescaler: 8-bit pcnt; when EN=1, pcnt counts 0..PRESC, asserting internal tick in the cycle pcnt==PRESC and wrapping to 0; when EN=0 pcnt SHALL hold 0.
REQ-018 On tick with VALUE!=0: VALUE <= VALUE-1.
REQ-019 On tick with VALUE==0: IF <= 1; if RELOAD=1 VALUE <= LOAD, else EN <= 0 and VALUE stays 0 (one-shot).
REQ-020 Periodic period SHALL be (LOAD+1)*(PRESC+1) pclk cycles between IF set events.
REQ-021 Write to LOAD SHALL also set VALUE <= pwdata and pcnt <= 0 on the same edge, overriding any decrement/reload that edge; IF set from a simultaneous tick SHALL still occur.
REQ-022 Write to CTRL SHALL take effect next edge; a tick on the same edge is processed with old CTRL; a CTRL write setting EN=1 SHALL override the one-shot EN clear on the same edge.
REQ-023 STATUS write with pwdata[0]=1 clears IF; if hardware sets IF on the same edge, set SHALL win.
REQ-024 irq SHALL equal IF & IE (combinational from registers, no glitch from APB inputs).
REQ-025 Clearing EN SHALL freeze VALUE and reset pcnt; re-setting EN resumes from frozen VALUE.
REQ-026 PRESC=0 SHALL produce a tick every enabled cycle; LOAD=0 with RELOAD=1 SHALL set IF every tick.

Reset
REQ-027 While prst=1 at an edge: CTRL=0, LOAD=0, VALUE=0, IF=0, pcnt=0; hence irq=0, pslverr=0, prdata=0 with psel=0.
REQ-028 Reset asserted mid-count SHALL abort counting immediately; APB access in the same cycle SHALL be ignored.

Verification
REQ-029 Write LOAD=4, CTRL=0x07 (PRESC=0) -> VALUE reads 4,3,2,1,0 over successive cycles; IF and irq rise on the 5th tick; VALUE reloads 4; IF again 5 cycles later.
REQ-030 LOAD=2, CTRL=0x0301 (PRESC=3, one-shot, IE=0) -> VALUE decrements every 4 cycles; IF=1 after 12 cycles; CTRL reads 0x0300 (EN cleared); irq stays 0.
REQ-031 IF=1, write STATUS=1 on the edge a new tick hits zero -> IF remains 1; then write STATUS=1 alone -> IF=0, irq=0.
REQ-032 Write VALUE offset 0x08 and read offset 0x14 -> pslverr=1 in access phase, no register change, read returns 0.
REQ-033 Count running at VALUE=0x100, assert prst for one cycle -> all registers read 0, irq=0, no further ticks.
REQ-034 Running periodic LOAD=10, write LOAD=3 mid-count -> VALUE reads 3 next cycle, pcnt restarted, next IF after 4 ticks.
